// File: rtl/jt12_eg_sched.sv
// Envelope generator sequencer: walks operator slots, stores per-slot envelope context,
// produces key edges and the shared eg_cnt, and writes datapath results back on clk_en.
module jt12_eg_sched #(
  parameter int unsigned SLOTS    = 24,
  parameter int unsigned EGW      = 10,
  parameter int unsigned CNTW     = 15,
  parameter int unsigned PRESCALE = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_en,
  input  logic            kon_we,
  input  logic [4:0]      kon_slot,
  input  logic            kon_val,
  output logic [4:0]      slot,
  output logic            zero,
  output logic [CNTW-1:0] eg_cnt,
  output logic            keyon_now,
  output logic            keyoff_now,
  output logic [2:0]      state_in,
  output logic [EGW-1:0]  eg_in,
  output logic            ssg_inv_in,
  output logic            cnt_in,
  input  logic [2:0]      state_next,
  input  logic [EGW-1:0]  pure_eg_out,
  input  logic            ssg_inv_out,
  input  logic            cnt_lsb
);

  localparam int unsigned SW = 5;
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [2:0] {
    EG_RELEASE = 3'b000,
    EG_ATTACK  = 3'b001,
    EG_DECAY   = 3'b010,
    EG_HOLD    = 3'b100
  } eg_state_e;

  logic [SW-1:0]   slot_q, slot_d;
  logic            zero_q, zero_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [CNTW-1:0] eg_cnt_q, eg_cnt_d;
  logic [2:0]      state_q [SLOTS];
  logic [2:0]      state_d [SLOTS];
  logic [EGW-1:0]  level_q [SLOTS];
  logic [EGW-1:0]  level_d [SLOTS];
  logic [SLOTS-1:0] inv_q, inv_d;
  logic [SLOTS-1:0] cnt_q, cnt_d;
  logic [SLOTS-1:0] key_q, key_d;
  logic [SLOTS-1:0] kprev_q, kprev_d;

  // Slot walk, prescaled envelope counter, write-back and asynchronous key writes
  always_comb begin
    slot_d   = slot_q;
    zero_d   = zero_q;
    pre_d    = pre_q;
    eg_cnt_d = eg_cnt_q;
    state_d  = state_q;
    level_d  = level_q;
    inv_d    = inv_q;
    cnt_d    = cnt_q;
    key_d    = key_q;
    kprev_d  = kprev_q;
    if (clk_en) begin
      slot_d = (slot_q == SW'(SLOTS - 1)) ? '0 : slot_q + SW'(1);
      zero_d = (slot_d == '0);
      if (slot_q == SW'(SLOTS - 1)) begin
        if (pre_q == PW'(PRESCALE - 1)) begin
          pre_d    = '0;
          eg_cnt_d = eg_cnt_q + CNTW'(1);
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      state_d[slot_q] = state_next;
      level_d[slot_q] = pure_eg_out;
      inv_d[slot_q]   = ssg_inv_out;
      cnt_d[slot_q]   = cnt_lsb;
      kprev_d[slot_q] = key_q[slot_q];
    end
    // Applied after the service so a same-slot write only shows on the next visit
    if (kon_we && (32'(kon_slot) < SLOTS)) key_d[kon_slot] = kon_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q   <= '0;
      zero_q   <= 1'b1;
      pre_q    <= '0;
      eg_cnt_q <= '0;
      for (int i = 0; i < int'(SLOTS); i++) begin
        state_q[i] <= EG_RELEASE;
        level_q[i] <= '1;
      end
      inv_q   <= '0;
      cnt_q   <= '0;
      key_q   <= '0;
      kprev_q <= '0;
    end else begin
      slot_q   <= slot_d;
      zero_q   <= zero_d;
      pre_q    <= pre_d;
      eg_cnt_q <= eg_cnt_d;
      state_q  <= state_d;
      level_q  <= level_d;
      inv_q    <= inv_d;
      cnt_q    <= cnt_d;
      key_q    <= key_d;
      kprev_q  <= kprev_d;
    end
  end

  assign slot       = slot_q;
  assign zero       = zero_q;
  assign eg_cnt     = eg_cnt_q;
  assign state_in   = state_q[slot_q];
  assign eg_in      = level_q[slot_q];
  assign ssg_inv_in = inv_q[slot_q];
  assign cnt_in     = cnt_q[slot_q];
  assign keyon_now  = key_q[slot_q] & ~kprev_q[slot_q];
  assign keyoff_now = ~key_q[slot_q] & kprev_q[slot_q];

endmodule

// File: tb/tb_jt12_eg_sched.sv
// Self-checking bench for jt12_eg_sched: directed scenarios plus random traffic against a slot-table model.
module tb_jt12_eg_sched;

  localparam int SLOTS = 24;

  logic        clk = 1'b0;
  logic        rst, clk_en, kon_we, kon_val;
  logic [4:0]  kon_slot;
  logic [2:0]  state_next;
  logic [9:0]  pure_eg_out;
  logic        ssg_inv_out, cnt_lsb;

  logic [4:0]  slot, slot_s;
  logic        zero, zero_s;
  logic [14:0] eg_cnt;
  logic [3:0]  eg_cnt_s;
  logic        keyon_now, keyoff_now, ssg_inv_in, cnt_in;
  logic        keyon_s, keyoff_s, ssg_s, cnt_s;
  logic [2:0]  state_in, state_s;
  logic [9:0]  eg_in, eg_s;

  jt12_eg_sched dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .kon_we(kon_we), .kon_slot(kon_slot),
    .kon_val(kon_val), .slot(slot), .zero(zero), .eg_cnt(eg_cnt),
    .keyon_now(keyon_now), .keyoff_now(keyoff_now), .state_in(state_in), .eg_in(eg_in),
    .ssg_inv_in(ssg_inv_in), .cnt_in(cnt_in), .state_next(state_next),
    .pure_eg_out(pure_eg_out), .ssg_inv_out(ssg_inv_out), .cnt_lsb(cnt_lsb)
  );

  // Narrow-counter copy so the eg_cnt wrap is reachable in a short run
  jt12_eg_sched #(.CNTW(4)) dut_s (
    .clk(clk), .rst(rst), .clk_en(clk_en), .kon_we(kon_we), .kon_slot(kon_slot),
    .kon_val(kon_val), .slot(slot_s), .zero(zero_s), .eg_cnt(eg_cnt_s),
    .keyon_now(keyon_s), .keyoff_now(keyoff_s), .state_in(state_s), .eg_in(eg_s),
    .ssg_inv_in(ssg_s), .cnt_in(cnt_s), .state_next(state_next),
    .pure_eg_out(pure_eg_out), .ssg_inv_out(ssg_inv_out), .cnt_lsb(cnt_lsb)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: slot table plus a count of enabled cycles since reset
  int m_n;
  int m_state [SLOTS];
  int m_lvl   [SLOTS];
  bit m_inv   [SLOTS];
  bit m_cnt   [SLOTS];
  bit m_key   [SLOTS];
  bit m_prev  [SLOTS];
  bit attack_stub = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_n = 0;
    for (int i = 0; i < SLOTS; i++) begin
      m_state[i] = 0; m_lvl[i] = 10'h3FF; m_inv[i] = 0; m_cnt[i] = 0;
      m_key[i] = 0; m_prev[i] = 0;
    end
  endfunction

  task automatic check_outputs();
    int s;
    s = m_n % SLOTS;
    check("slot", 32'(slot), 32'(s));
    check("zero", 32'(zero), 32'(s == 0));
    check("eg_cnt", 32'(eg_cnt), 32'((m_n / 72) % 32768));
    check("slot_s", 32'(slot_s), 32'(s));
    check("eg_cnt_s", 32'(eg_cnt_s), 32'((m_n / 72) % 16));
    check("state_in", 32'(state_in), 32'(m_state[s]));
    check("eg_in", 32'(eg_in), 32'(m_lvl[s]));
    check("ssg_inv_in", 32'(ssg_inv_in), 32'(m_inv[s]));
    check("cnt_in", 32'(cnt_in), 32'(m_cnt[s]));
    check("keyon_now", 32'(keyon_now), 32'(m_key[s] && !m_prev[s]));
    check("keyoff_now", 32'(keyoff_now), 32'(!m_key[s] && m_prev[s]));
  endtask

  // One cycle: check at negedge, drive, let the posedge happen, advance the model
  task automatic step(input logic en, input logic we, input logic [4:0] ks,
                      input logic kv, input logic r);
    int s;
    check_outputs();
    clk_en = en; kon_we = we; kon_slot = ks; kon_val = kv; rst = r;
    state_next  = attack_stub ? 3'b001 : 3'($urandom);
    pure_eg_out = 10'($urandom);
    ssg_inv_out = 1'($urandom);
    cnt_lsb     = 1'($urandom);
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (en) begin
        s = m_n % SLOTS;
        m_state[s] = int'(state_next);
        m_lvl[s]   = int'(pure_eg_out);
        m_inv[s]   = ssg_inv_out;
        m_cnt[s]   = cnt_lsb;
        m_prev[s]  = m_key[s];
        m_n++;
      end
      if (we && int'(ks) < SLOTS) m_key[ks] = kv;
    end
    @(negedge clk);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < SLOTS && (m_n % SLOTS) != target; i++)
      step(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b0; kon_we = 1'b0; kon_slot = '0; kon_val = 1'b0;
    state_next = '0; pure_eg_out = '0; ssg_inv_out = 1'b0; cnt_lsb = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Continuous walk: two full prescaler periods
    run(144);
    check("eg_cnt_after_144", 32'(eg_cnt), 32'd2);

    // Key-on written ahead of the slot visit, datapath answers ATTACK
    attack_stub = 1'b1;
    run_to(2);
    step(1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    run(30);
    check("slot5_attack", 32'(m_state[5]), 32'd1);

    // Write collides with the service of the same slot
    run_to(7);
    step(1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
    run(50);

    // On then off before the visit: no edge
    run_to(3);
    step(1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    step(1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
    run(30);

    // Narrow counter wraps, then clk_en low freezes everything
    attack_stub = 1'b0;
    while (m_n < 1200) step(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    check("eg_cnt_s_wrapped", 32'(eg_cnt_s), 32'((m_n / 72) % 16));
    repeat (10) step(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

    // Mid-frame reset with slot 4 in ATTACK and a write in flight
    attack_stub = 1'b1;
    run_to(5);
    attack_stub = 1'b0;
    run_to(13);
    step(1'b1, 1'b1, 5'd4, 1'b1, 1'b1);
    check("rst_slot", 32'(slot), 32'd0);
    check("rst_eg_in", 32'(eg_in), 32'h3FF);
    run(30);

    // Random traffic including ignored slot numbers and sporadic resets
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
           5'($urandom), 1'($urandom), 1'($urandom_range(0, 199) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
